// File: rtl/lp_bus_encoder.sv
// lp_bus_encoder: multi-mode low-power bus encoder (binary, Gray, T0, bus-invert)
// with a registered bus, one redundancy line and a saturating toggle counter.
module lp_bus_encoder #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STRIDE = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] A,
  input  logic             clr,
  output logic [WIDTH-1:0] B,
  output logic             X,
  output logic [CNT_W-1:0] tcount
);

  typedef enum logic [1:0] {
    MODE_BIN  = 2'd0,
    MODE_GRAY = 2'd1,
    MODE_T0   = 2'd2,
    MODE_BI   = 2'd3
  } mode_e;

  localparam int unsigned PW = $clog2(WIDTH + 2);
  localparam int unsigned SW = ((CNT_W > PW) ? CNT_W : PW) + 1;
  localparam logic [SW-1:0] CNT_MAX = SW'({CNT_W{1'b1}});

  logic [WIDTH-1:0] b_q, b_d;
  logic             x_q, x_d;
  logic [WIDTH-1:0] prev_a_q, prev_a_d;
  logic             t0_valid_q, t0_valid_d;
  logic [CNT_W-1:0] tcount_q, tcount_d;

  logic [WIDTH-1:0] diff_a;
  logic [PW-1:0]    ham;
  logic [WIDTH:0]   bus_diff;
  logic [PW-1:0]    toggles;
  logic [SW-1:0]    sum;
  mode_e            mode_sel;

  // Next-state encoding and toggle accounting
  always_comb begin
    b_d        = b_q;
    x_d        = x_q;
    prev_a_d   = prev_a_q;
    t0_valid_d = t0_valid_q;
    tcount_d   = tcount_q;
    mode_sel   = mode_e'(mode);
    diff_a     = A ^ b_q;
    ham        = '0;
    toggles    = '0;
    bus_diff   = '0;
    sum        = '0;

    for (int unsigned i = 0; i < WIDTH; i++) begin
      ham = ham + PW'(diff_a[i]);
    end

    if (en) begin
      prev_a_d   = A;
      t0_valid_d = (mode_sel == MODE_T0);
      unique case (mode_sel)
        MODE_BIN: begin
          b_d = A;
          x_d = 1'b0;
        end
        MODE_GRAY: begin
          b_d = A ^ (A >> 1);
          x_d = 1'b0;
        end
        MODE_T0: begin
          if (t0_valid_q && (A == prev_a_q + WIDTH'(STRIDE))) begin
            x_d = 1'b1;
          end else begin
            b_d = A;
            x_d = 1'b0;
          end
        end
        MODE_BI: begin
          if (ham > PW'(WIDTH / 2)) begin
            b_d = ~A;
            x_d = 1'b1;
          end else begin
            b_d = A;
            x_d = 1'b0;
          end
        end
        default: begin
          b_d = A;
          x_d = 1'b0;
        end
      endcase

      bus_diff = {x_d, b_d} ^ {x_q, b_q};
      for (int unsigned i = 0; i <= WIDTH; i++) begin
        toggles = toggles + PW'(bus_diff[i]);
      end
      sum = SW'(tcount_q) + SW'(toggles);
      tcount_d = (sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : sum[CNT_W-1:0];
    end

    if (clr) begin
      tcount_d = '0;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge ck) begin
    if (!rst) begin
      b_q        <= '0;
      x_q        <= 1'b0;
      prev_a_q   <= '0;
      t0_valid_q <= 1'b0;
      tcount_q   <= '0;
    end else begin
      b_q        <= b_d;
      x_q        <= x_d;
      prev_a_q   <= prev_a_d;
      t0_valid_q <= t0_valid_d;
      tcount_q   <= tcount_d;
    end
  end

  assign B      = b_q;
  assign X      = x_q;
  assign tcount = tcount_q;

endmodule

// File: tb/tb_lp_bus_encoder.sv
// Directed + random bench for lp_bus_encoder (WIDTH=8, STRIDE=1, CNT_W=4).
module tb_lp_bus_encoder;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;

  logic             ck;
  logic             rst;
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] A;
  logic             clr;
  logic [WIDTH-1:0] B;
  logic             X;
  logic [CNT_W-1:0] tcount;

  typedef struct {
    logic [WIDTH-1:0] b;
    logic             x;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb[$];

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] mb, mprev;
  logic             mx, mt0v;
  int               mcnt;

  lp_bus_encoder #(
    .WIDTH (WIDTH),
    .STRIDE(1),
    .CNT_W (CNT_W)
  ) dut (
    .ck    (ck),
    .rst   (rst),
    .en    (en),
    .mode  (mode),
    .A     (A),
    .clr   (clr),
    .B     (B),
    .X     (X),
    .tcount(tcount)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, predict with the reference model, compare after the edge.
  task automatic step(input logic r, input logic e, input logic [1:0] m,
                      input logic [WIDTH-1:0] a, input logic c);
    exp_t             ex;
    logic [WIDTH-1:0] nb, seq;
    logic             nx;
    int               d;
    rst = r; en = e; mode = m; A = a; clr = c;
    if (!r) begin
      mb = '0; mx = 1'b0; mprev = '0; mt0v = 1'b0; mcnt = 0;
    end else begin
      if (e) begin
        nb = mb; nx = mx;
        seq = mprev + 8'd1;
        case (m)
          2'd0: begin nb = a; nx = 1'b0; end
          2'd1: begin nb = a ^ {1'b0, a[WIDTH-1:1]}; nx = 1'b0; end
          2'd2: begin
            if (mt0v && a == seq) nx = 1'b1;
            else begin nb = a; nx = 1'b0; end
          end
          default: begin
            if ($countones(a ^ mb) > WIDTH / 2) begin nb = ~a; nx = 1'b1; end
            else begin nb = a; nx = 1'b0; end
          end
        endcase
        d = $countones({nx, nb} ^ {mx, mb});
        mcnt = (mcnt + d > 15) ? 15 : mcnt + d;
        mb = nb; mx = nx; mprev = a; mt0v = (m == 2'd2);
      end
      if (c) mcnt = 0;
    end
    ex.b = mb; ex.x = mx; ex.cnt = CNT_W'(mcnt);
    sb.push_back(ex);
    @(posedge ck);
    #1;
    ex = sb.pop_front();
    chk("sb_B", 32'(B), 32'(ex.b));
    chk("sb_X", 32'(X), 32'(ex.x));
    chk("sb_tcount", 32'(tcount), 32'(ex.cnt));
  endtask

  task automatic expect_bx(input string tag, input logic [WIDTH-1:0] eb, input logic ex);
    chk({tag, "_B"}, 32'(B), 32'(eb));
    chk({tag, "_X"}, 32'(X), 32'(ex));
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; mode = 2'd0; A = '0; clr = 1'b0;
    mb = '0; mx = 1'b0; mprev = '0; mt0v = 1'b0; mcnt = 0;

    // Reset dominates en
    step(1'b0, 1'b1, 2'd1, 8'hAA, 1'b0);
    step(1'b0, 1'b1, 2'd1, 8'hAA, 1'b0);
    expect_bx("rst", 8'h00, 1'b0);
    chk("rst_tcount", 32'(tcount), 32'd0);
    step(1'b1, 1'b1, 2'd1, 8'h05, 1'b0);
    expect_bx("gray05", 8'h07, 1'b0);

    // T0 sequence with a hold cycle and wrap-around
    step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    step(1'b1, 1'b1, 2'd2, 8'h10, 1'b0); expect_bx("t0_10", 8'h10, 1'b0);
    step(1'b1, 1'b1, 2'd2, 8'h11, 1'b0); expect_bx("t0_11", 8'h10, 1'b1);
    step(1'b1, 1'b0, 2'd2, 8'h77, 1'b0); expect_bx("t0_hold", 8'h10, 1'b1);
    step(1'b1, 1'b1, 2'd2, 8'h12, 1'b0); expect_bx("t0_12", 8'h10, 1'b1);
    step(1'b1, 1'b1, 2'd2, 8'h40, 1'b0); expect_bx("t0_40", 8'h40, 1'b0);
    step(1'b1, 1'b1, 2'd2, 8'h41, 1'b0); expect_bx("t0_41", 8'h40, 1'b1);
    step(1'b1, 1'b1, 2'd2, 8'hFF, 1'b0); expect_bx("t0_FF", 8'hFF, 1'b0);
    step(1'b1, 1'b1, 2'd2, 8'h00, 1'b0); expect_bx("t0_wrap", 8'hFF, 1'b1);

    // Bus-invert including the tie case
    step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    step(1'b1, 1'b1, 2'd3, 8'hF0, 1'b0); expect_bx("bi_F0", 8'hF0, 1'b0);
    chk("bi_cnt4", 32'(tcount), 32'd4);
    step(1'b1, 1'b1, 2'd3, 8'h0F, 1'b0); expect_bx("bi_0F", 8'hF0, 1'b1);
    chk("bi_cnt5", 32'(tcount), 32'd5);
    step(1'b1, 1'b1, 2'd3, 8'hF1, 1'b0); expect_bx("bi_F1", 8'hF1, 1'b0);
    chk("bi_cnt7", 32'(tcount), 32'd7);

    // Mode change breaks T0 history
    step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    step(1'b1, 1'b1, 2'd2, 8'h20, 1'b0); expect_bx("mc_20", 8'h20, 1'b0);
    step(1'b1, 1'b1, 2'd1, 8'h21, 1'b0); expect_bx("mc_gray21", 8'h31, 1'b0);
    step(1'b1, 1'b1, 2'd2, 8'h22, 1'b0); expect_bx("mc_22", 8'h22, 1'b0);

    // Counter saturation and clear
    step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    step(1'b1, 1'b1, 2'd0, 8'h00, 1'b0); chk("cnt_0", 32'(tcount), 32'd0);
    step(1'b1, 1'b1, 2'd0, 8'hFF, 1'b0); chk("cnt_8", 32'(tcount), 32'd8);
    step(1'b1, 1'b1, 2'd0, 8'h00, 1'b0); chk("cnt_sat", 32'(tcount), 32'd15);
    step(1'b1, 1'b1, 2'd0, 8'hFF, 1'b0); chk("cnt_sat2", 32'(tcount), 32'd15);
    step(1'b1, 1'b1, 2'd0, 8'h00, 1'b1); chk("cnt_clr_en", 32'(tcount), 32'd0);
    step(1'b1, 1'b1, 2'd0, 8'hFF, 1'b0); chk("cnt_8b", 32'(tcount), 32'd8);
    step(1'b1, 1'b0, 2'd0, 8'h00, 1'b1); chk("cnt_clr_noen", 32'(tcount), 32'd0);

    // Reset in the middle of a T0 run
    step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    step(1'b1, 1'b1, 2'd2, 8'h10, 1'b0);
    step(1'b1, 1'b1, 2'd2, 8'h11, 1'b0); expect_bx("mid_pre", 8'h10, 1'b1);
    step(1'b0, 1'b1, 2'd2, 8'h12, 1'b1); expect_bx("mid_rst", 8'h00, 1'b0);
    step(1'b1, 1'b1, 2'd2, 8'h11, 1'b0); expect_bx("mid_post", 8'h11, 1'b0);

    // Random mixed traffic against the model
    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0),
           2'($urandom_range(0, 3)),
           ($urandom_range(0, 1) != 0) ? mprev + 8'd1 : 8'($urandom),
           ($urandom_range(0, 19) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
